// File: rtl/conv1d_sequencer.sv
// conv1d_sequencer: CFU command front-end for the conv1d engine.
// Forwards buffer commands as engine strobes and walks MAC steps for a run.
module conv1d_sequencer #(
    parameter int MAX_INPUT_SIZE     = 1024,
    parameter int MAX_INPUT_CHANNELS = 128,
    parameter int LANES              = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_payload_function_id,
    input  logic [31:0] cmd_payload_inputs_0,
    input  logic [31:0] cmd_payload_inputs_1,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_payload_outputs_0,
    output logic        eng_valid,
    output logic [6:0]  eng_cmd,
    output logic [31:0] eng_inp0,
    output logic [31:0] eng_inp1,
    input  logic [31:0] eng_ret,
    output logic        mac_valid,
    input  logic        mac_ready,
    output logic [$clog2(MAX_INPUT_SIZE)-1:0]     mac_out_idx,
    output logic [$clog2(MAX_INPUT_CHANNELS)-1:0] mac_chan_base,
    output logic        mac_first,
    output logic        mac_last
);

    localparam int IDX_W = $clog2(MAX_INPUT_SIZE);
    localparam int LEN_W = $clog2(MAX_INPUT_SIZE + 1);
    localparam int CB_W  = $clog2(MAX_INPUT_CHANNELS);
    localparam int CH_W  = $clog2(MAX_INPUT_CHANNELS + 1);

    localparam logic [CH_W-1:0] LANES_CH  = CH_W'(LANES);
    localparam logic [CB_W-1:0] LANES_CB  = CB_W'(LANES);
    localparam logic [31:0]     LANE_MASK = 32'(LANES - 1);
    localparam logic [31:0]     MAX_LEN   = 32'(MAX_INPUT_SIZE);
    localparam logic [31:0]     MAX_CH    = 32'(MAX_INPUT_CHANNELS);
    localparam logic [31:0]     ERR_WORD  = 32'hFFFF_FFFF;

    localparam logic [6:0] F_START = 7'd4;
    localparam logic [6:0] F_LEN   = 7'd9;
    localparam logic [6:0] F_CH    = 7'd10;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RUN,
        RESP
    } state_t;

    state_t state;
    state_t state_nx;

    logic [LEN_W-1:0] cfg_len;
    logic [CH_W-1:0]  cfg_ch;
    logic [IDX_W-1:0] out_idx;
    logic [CB_W-1:0]  chan_base;
    logic [31:0]      step_cnt;

    logic [6:0] funct7;
    logic [2:0] unused_funct3;
    logic       is_pass;
    logic       is_start;
    logic       is_len;
    logic       is_ch;
    logic       len_ok;
    logic       ch_ok;
    logic       accept;
    logic       mac_fire;
    logic       group_first;
    logic       group_last;
    logic       out_last;
    logic       run_done;

    assign funct7        = cmd_payload_function_id[9:3];
    assign unused_funct3 = cmd_payload_function_id[2:0];

    assign is_pass  = (funct7 < 7'd8) && (funct7 != F_START);
    assign is_start = (funct7 == F_START);
    assign is_len   = (funct7 == F_LEN);
    assign is_ch    = (funct7 == F_CH);

    assign len_ok = (cmd_payload_inputs_0 != 32'd0)
                 && (cmd_payload_inputs_0 <= MAX_LEN);

    // Channel count must split evenly into LANES-wide groups.
    assign ch_ok = (cmd_payload_inputs_0 != 32'd0)
                && (cmd_payload_inputs_0 <= MAX_CH)
                && ((cmd_payload_inputs_0 & LANE_MASK) == 32'd0);

    assign accept   = (state == IDLE) && cmd_valid;
    assign mac_fire = (state == RUN) && mac_ready;

    assign group_first = (chan_base == '0);
    assign group_last  = (CH_W'(chan_base) == cfg_ch - LANES_CH);
    assign out_last    = (LEN_W'(out_idx) == cfg_len - LEN_W'(1));
    assign run_done    = mac_fire && group_last && out_last;

    assign mac_out_idx   = out_idx;
    assign mac_chan_base = chan_base;
    assign mac_first     = (state == RUN) && group_first;
    assign mac_last      = (state == RUN) && group_last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cmd_ready = 1'b0;
        eng_valid = 1'b0;
        mac_valid = 1'b0;
        rsp_valid = 1'b0;
        unique case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    unique case (1'b1)
                        is_pass:  state_nx = ISSUE;
                        is_start: begin
                            if (cfg_len == '0) begin
                                state_nx = RESP;
                            end else begin
                                state_nx = RUN;
                            end
                        end
                        default:  state_nx = RESP;
                    endcase
                end
            end
            ISSUE: begin
                eng_valid = 1'b1;
                state_nx  = WAIT;
            end
            WAIT: begin
                state_nx = RESP;
            end
            RUN: begin
                mac_valid = 1'b1;
                if (run_done) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cfg_len               <= '0;
            cfg_ch                <= LANES_CH;
            out_idx               <= '0;
            chan_base             <= '0;
            step_cnt              <= '0;
            eng_cmd               <= '0;
            eng_inp0              <= '0;
            eng_inp1              <= '0;
            rsp_payload_outputs_0 <= '0;
        end else begin
            if (accept) begin
                unique case (1'b1)
                    is_pass: begin
                        eng_cmd  <= funct7;
                        eng_inp0 <= cmd_payload_inputs_0;
                        eng_inp1 <= cmd_payload_inputs_1;
                    end
                    is_len: begin
                        if (len_ok) begin
                            cfg_len <= cmd_payload_inputs_0[LEN_W-1:0];
                            rsp_payload_outputs_0 <= '0;
                        end else begin
                            rsp_payload_outputs_0 <= ERR_WORD;
                        end
                    end
                    is_ch: begin
                        if (ch_ok) begin
                            cfg_ch <= cmd_payload_inputs_0[CH_W-1:0];
                            rsp_payload_outputs_0 <= '0;
                        end else begin
                            rsp_payload_outputs_0 <= ERR_WORD;
                        end
                    end
                    is_start: begin
                        out_idx               <= '0;
                        chan_base             <= '0;
                        step_cnt              <= '0;
                        rsp_payload_outputs_0 <= '0;
                    end
                    default: begin
                        rsp_payload_outputs_0 <= ERR_WORD;
                    end
                endcase
            end

            if (state == WAIT) begin
                rsp_payload_outputs_0 <= eng_ret;
            end

            // Walk channel groups inside each output position.
            if (mac_fire) begin
                step_cnt <= step_cnt + 32'd1;
                if (group_last) begin
                    chan_base <= '0;
                    out_idx   <= out_idx + IDX_W'(1);
                end else begin
                    chan_base <= chan_base + LANES_CB;
                end
                if (run_done) begin
                    rsp_payload_outputs_0 <= step_cnt + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv1d_sequencer.sv
// Self-checking bench for conv1d_sequencer.
// Scoreboard queues hold expected MAC steps and responses.
module tb_conv1d_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [9:0]  cmd_payload_function_id = '0;
    logic [31:0] cmd_payload_inputs_0 = '0;
    logic [31:0] cmd_payload_inputs_1 = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_payload_outputs_0;
    logic        eng_valid;
    logic [6:0]  eng_cmd;
    logic [31:0] eng_inp0;
    logic [31:0] eng_inp1;
    logic [31:0] eng_ret = '0;
    logic        mac_valid;
    logic        mac_ready = 1'b1;
    logic [9:0]  mac_out_idx;
    logic [6:0]  mac_chan_base;
    logic        mac_first;
    logic        mac_last;

    typedef struct packed {
        logic [9:0] idx;
        logic [6:0] cb;
        logic       first;
        logic       last;
    } mac_t;

    mac_t        exp_mac[$];
    logic [31:0] exp_rsp[$];

    int n_cmp = 0;
    int n_err = 0;
    int hs_count = 0;
    int eng_pulses = 0;
    int overlap = 0;
    logic [31:0] eng_model = '0;

    localparam logic [31:0] ERR = 32'hFFFF_FFFF;

    conv1d_sequencer dut (
        .clk                     (clk),
        .reset                   (reset),
        .cmd_valid               (cmd_valid),
        .cmd_ready               (cmd_ready),
        .cmd_payload_function_id (cmd_payload_function_id),
        .cmd_payload_inputs_0    (cmd_payload_inputs_0),
        .cmd_payload_inputs_1    (cmd_payload_inputs_1),
        .rsp_valid               (rsp_valid),
        .rsp_ready               (rsp_ready),
        .rsp_payload_outputs_0   (rsp_payload_outputs_0),
        .eng_valid               (eng_valid),
        .eng_cmd                 (eng_cmd),
        .eng_inp0                (eng_inp0),
        .eng_inp1                (eng_inp1),
        .eng_ret                 (eng_ret),
        .mac_valid               (mac_valid),
        .mac_ready               (mac_ready),
        .mac_out_idx             (mac_out_idx),
        .mac_chan_base           (mac_chan_base),
        .mac_first               (mac_first),
        .mac_last                (mac_last)
    );

    always #5 clk = ~clk;

    // Engine read data is registered: valid the cycle after the strobe.
    always @(posedge clk) begin
        if (eng_valid) eng_ret <= eng_model;
    end

    always @(posedge clk) begin
        if (mac_valid && mac_ready) hs_count++;
        if (eng_valid) eng_pulses++;
        if (eng_valid && mac_valid) overlap++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_cmd(input logic [6:0] f,
                            input logic [31:0] a,
                            input logic [31:0] b);
        cmd_payload_function_id = {f, 3'b000};
        cmd_payload_inputs_0 = a;
        cmd_payload_inputs_1 = b;
        cmd_valid = 1'b1;
        for (int i = 0; i < 64 && !cmd_ready; i++) @(negedge clk);
        if (!cmd_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_cmd: cmd_ready=0 required 1 within 64 cycles");
        end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output logic [31:0] data, output bit got);
        got = 1'b0;
        data = 'x;
        for (int i = 0; i < 200; i++) begin
            if (rsp_valid) begin
                got = 1'b1;
                data = rsp_payload_outputs_0;
                break;
            end
            @(negedge clk);
        end
        if (got) @(negedge clk);
    endtask

    task automatic cmd_rsp(input logic [6:0] f, input logic [31:0] a,
                           output logic [31:0] data, output bit got);
        send_cmd(f, a, 32'd0);
        wait_rsp(data, got);
    endtask

    task automatic test_reset;
        n_cmp++;
        if ({cmd_ready, rsp_valid, eng_valid, mac_valid, mac_first, mac_last}
            !== 6'b100000) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b required 100000",
                     {cmd_ready, rsp_valid, eng_valid,
                      mac_valid, mac_first, mac_last});
        end
        n_cmp++;
        if ({eng_cmd, eng_inp0, eng_inp1, rsp_payload_outputs_0,
             mac_out_idx, mac_chan_base} !== '0) begin
            n_err++;
            $display("FAIL reset_data: eng_cmd=%h inp0=%h inp1=%h rsp=%h required 0",
                     eng_cmd, eng_inp0, eng_inp1, rsp_payload_outputs_0);
        end
    endtask

    task automatic test_empty_start;
        logic [31:0] d;
        logic [31:0] e;
        bit g;
        int base;
        base = hs_count;
        exp_rsp.push_back(32'd0);
        send_cmd(7'd4, 32'd0, 32'd0);
        n_cmp++;
        if ({mac_valid, rsp_valid} !== 2'b01) begin
            n_err++;
            $display("FAIL empty_start_state: mac_valid/rsp_valid=%b required 01",
                     {mac_valid, rsp_valid});
        end
        wait_rsp(d, g);
        e = exp_rsp.pop_front();
        n_cmp++;
        if (!g || d !== e || hs_count != base) begin
            n_err++;
            $display("FAIL empty_start: got %h steps %0d required %h steps 0",
                     d, hs_count - base, e);
        end
    endtask

    task automatic test_pass_through;
        logic [31:0] d;
        logic [31:0] e;
        bit g;
        int base;
        base = eng_pulses;
        eng_model = 32'h1234_5678;
        exp_rsp.push_back(eng_model);
        send_cmd(7'd1, 32'd5, 32'h0706_0504);
        n_cmp++;
        if ({eng_valid, rsp_valid, cmd_ready} !== 3'b100) begin
            n_err++;
            $display("FAIL pt_issue: eng/rsp/cmd_ready=%b required 100",
                     {eng_valid, rsp_valid, cmd_ready});
        end
        n_cmp++;
        if ({eng_cmd, eng_inp0, eng_inp1} !== {7'd1, 32'd5, 32'h0706_0504}) begin
            n_err++;
            $display("FAIL pt_fields: cmd=%h inp0=%h inp1=%h required 1 5 07060504",
                     eng_cmd, eng_inp0, eng_inp1);
        end
        @(negedge clk);
        n_cmp++;
        if ({eng_valid, rsp_valid, eng_cmd, eng_inp0, eng_inp1}
            !== {2'b00, 7'd1, 32'd5, 32'h0706_0504}) begin
            n_err++;
            $display("FAIL pt_wait: eng=%b rsp=%b cmd=%h inp0=%h inp1=%h",
                     eng_valid, rsp_valid, eng_cmd, eng_inp0, eng_inp1);
        end
        @(negedge clk);
        e = exp_rsp.pop_front();
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_payload_outputs_0 !== e) begin
            n_err++;
            $display("FAIL pt_resp: rsp_valid=%b data=%h required 1 %h",
                     rsp_valid, rsp_payload_outputs_0, e);
        end
        @(negedge clk);
        n_cmp++;
        if (eng_pulses - base != 1 || {rsp_valid, cmd_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL pt_done: pulses=%0d rsp/ready=%b required 1 01",
                     eng_pulses - base, {rsp_valid, cmd_ready});
        end

        eng_model = 32'hDEAD_BEEF;
        exp_rsp.push_back(eng_model);
        cmd_rsp(7'd5, 32'h10, d, g);
        e = exp_rsp.pop_front();
        n_cmp++;
        if (!g || d !== e) begin
            n_err++;
            $display("FAIL pt_read: got %h required %h", d, e);
        end

        base = eng_pulses;
        exp_rsp.push_back(ERR);
        cmd_rsp(7'd20, 32'h3, d, g);
        e = exp_rsp.pop_front();
        n_cmp++;
        if (!g || d !== e || eng_pulses != base) begin
            n_err++;
            $display("FAIL unknown_f7: got %h pulses %0d required %h pulses 0",
                     d, eng_pulses - base, e);
        end
    endtask

    task automatic test_run;
        logic [31:0] d;
        logic [31:0] e;
        bit g;
        int base;
        int bubbles;
        bit started;
        exp_rsp.push_back(32'd0);
        cmd_rsp(7'd9, 32'd3, d, g);
        e = exp_rsp.pop_front();
        n_cmp++;
        if (!g || d !== e) begin
            n_err++;
            $display("FAIL run_set_len: got %h required %h", d, e);
        end
        exp_rsp.push_back(32'd0);
        cmd_rsp(7'd10, 32'd8, d, g);
        e = exp_rsp.pop_front();
        n_cmp++;
        if (!g || d !== e) begin
            n_err++;
            $display("FAIL run_set_ch: got %h required %h", d, e);
        end
        for (int o = 0; o < 3; o++) begin
            for (int c = 0; c < 8; c += 4) begin
                mac_t m;
                m.idx = 10'(o);
                m.cb = 7'(c);
                m.first = (c == 0);
                m.last = (c == 4);
                exp_mac.push_back(m);
            end
        end
        exp_rsp.push_back(32'd6);
        mac_ready = 1'b1;
        base = hs_count;
        bubbles = 0;
        started = 1'b0;
        send_cmd(7'd4, 32'd0, 32'd0);
        for (int i = 0; i < 200; i++) begin
            if (rsp_valid) break;
            if (mac_valid) begin
                mac_t m;
                started = 1'b1;
                m = exp_mac.pop_front();
                n_cmp++;
                if ({cmd_ready, mac_out_idx, mac_chan_base, mac_first, mac_last}
                    !== {1'b0, m}) begin
                    n_err++;
                    $display("FAIL run_step: ready=%b got %0d,%0d,%b,%b required %0d,%0d,%b,%b",
                             cmd_ready, mac_out_idx, mac_chan_base, mac_first,
                             mac_last, m.idx, m.cb, m.first, m.last);
                end
            end else if (started) begin
                bubbles++;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (hs_count - base != 6 || bubbles != 0 || exp_mac.size() != 0) begin
            n_err++;
            $display("FAIL run_count: steps=%0d bubbles=%0d left=%0d required 6 0 0",
                     hs_count - base, bubbles, exp_mac.size());
        end
        wait_rsp(d, g);
        e = exp_rsp.pop_front();
        n_cmp++;
        if (!g || d !== e) begin
            n_err++;
            $display("FAIL run_resp: got %h required %h", d, e);
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] d;
        logic [31:0] e;
        bit g;
        int base;
        mac_t m;
        exp_rsp.push_back(32'd0);
        cmd_rsp(7'd9, 32'd1, d, g);
        e = exp_rsp.pop_front();
        exp_rsp.push_back(32'd0);
        cmd_rsp(7'd10, 32'd4, d, g);
        e = e | exp_rsp.pop_front();
        n_cmp++;
        if (!g || d !== e) begin
            n_err++;
            $display("FAIL bp_cfg: got %h required %h", d, e);
        end
        m.idx = '0;
        m.cb = '0;
        m.first = 1'b1;
        m.last = 1'b1;
        exp_mac.push_back(m);
        exp_rsp.push_back(32'd1);
        mac_ready = 1'b0;
        base = hs_count;
        send_cmd(7'd4, 32'd0, 32'd0);
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if ({mac_valid, mac_out_idx, mac_chan_base, mac_first, mac_last}
                !== {1'b1, exp_mac[0]}) begin
                n_err++;
                $display("FAIL bp_stall%0d: valid=%b got %0d,%0d,%b,%b", i,
                         mac_valid, mac_out_idx, mac_chan_base,
                         mac_first, mac_last);
            end
            @(negedge clk);
        end
        mac_ready = 1'b1;
        m = exp_mac.pop_front();
        @(negedge clk);
        n_cmp++;
        if (hs_count - base != 1 || mac_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_steps: steps=%0d mac_valid=%b required 1 0",
                     hs_count - base, mac_valid);
        end
        wait_rsp(d, g);
        e = exp_rsp.pop_front();
        n_cmp++;
        if (!g || d !== e) begin
            n_err++;
            $display("FAIL bp_resp: got %h required %h", d, e);
        end
    endtask

    task automatic test_config_rejects;
        logic [6:0]  fs[5] = '{7'd10, 7'd10, 7'd10, 7'd9, 7'd9};
        logic [31:0] vs[5] = '{32'd6, 32'd0, 32'd132, 32'd1025, 32'd0};
        logic [31:0] d;
        logic [31:0] e;
        bit g;
        int base;
        for (int i = 0; i < 5; i++) begin
            exp_rsp.push_back(ERR);
            cmd_rsp(fs[i], vs[i], d, g);
            e = exp_rsp.pop_front();
            n_cmp++;
            if (!g || d !== e) begin
                n_err++;
                $display("FAIL reject f7=%0d val=%0d: got %h required %h",
                         fs[i], vs[i], d, e);
            end
        end
        exp_rsp.push_back(32'd1);
        base = hs_count;
        cmd_rsp(7'd4, 32'd0, d, g);
        e = exp_rsp.pop_front();
        n_cmp++;
        if (!g || d !== e || hs_count - base != 1) begin
            n_err++;
            $display("FAIL reject_keep: got %h steps %0d required %h steps 1",
                     d, hs_count - base, e);
        end
    endtask

    task automatic test_reset_mid_run;
        logic [31:0] d;
        logic [31:0] e;
        bit g;
        int base;
        bit seen;
        exp_rsp.push_back(32'd0);
        cmd_rsp(7'd9, 32'd1024, d, g);
        e = exp_rsp.pop_front();
        n_cmp++;
        if (!g || d !== e) begin
            n_err++;
            $display("FAIL max_len: got %h required %h", d, e);
        end
        exp_rsp.push_back(32'd0);
        cmd_rsp(7'd10, 32'd128, d, g);
        e = exp_rsp.pop_front();
        n_cmp++;
        if (!g || d !== e) begin
            n_err++;
            $display("FAIL max_ch: got %h required %h", d, e);
        end
        base = hs_count;
        send_cmd(7'd4, 32'd0, 32'd0);
        for (int i = 0; i < 500 && hs_count - base < 100; i++) @(negedge clk);
        n_cmp++;
        if (hs_count - base != 100 || mac_valid !== 1'b1) begin
            n_err++;
            $display("FAIL mid_run_steps: steps=%0d mac_valid=%b required 100 1",
                     hs_count - base, mac_valid);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({mac_valid, cmd_ready, rsp_valid} !== 3'b010) begin
            n_err++;
            $display("FAIL async_abort: mac/ready/rsp=%b required 010",
                     {mac_valid, cmd_ready, rsp_valid});
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid || mac_valid) seen = 1'b1;
            @(negedge clk);
        end
        n_cmp++;
        if (seen) begin
            n_err++;
            $display("FAIL abort_quiet: rsp/mac activity=1 required 0");
        end
        exp_rsp.push_back(32'd0);
        cmd_rsp(7'd9, 32'd2, d, g);
        e = exp_rsp.pop_front();
        exp_rsp.push_back(32'd0);
        cmd_rsp(7'd10, 32'd4, d, g);
        e = e | exp_rsp.pop_front();
        n_cmp++;
        if (!g || d !== e) begin
            n_err++;
            $display("FAIL post_reset_cfg: got %h required %h", d, e);
        end
        exp_rsp.push_back(32'd2);
        base = hs_count;
        cmd_rsp(7'd4, 32'd0, d, g);
        e = exp_rsp.pop_front();
        n_cmp++;
        if (!g || d !== e || hs_count - base != 2) begin
            n_err++;
            $display("FAIL post_reset_run: got %h steps %0d required %h steps 2",
                     d, hs_count - base, e);
        end
    endtask

    task automatic test_response_hold;
        logic [31:0] e;
        bit got;
        eng_model = 32'hCAFE_F00D;
        exp_rsp.push_back(eng_model);
        rsp_ready = 1'b0;
        send_cmd(7'd2, 32'h40, 32'h1);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (rsp_valid) got = 1'b1;
            else @(negedge clk);
        end
        e = exp_rsp.pop_front();
        cmd_payload_function_id = {7'd9, 3'b000};
        cmd_payload_inputs_0 = 32'd7;
        cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (!got || {rsp_valid, cmd_ready} !== 2'b10
                || rsp_payload_outputs_0 !== e) begin
                n_err++;
                $display("FAIL hold%0d: rsp/ready=%b data=%h required 10 %h", i,
                         {rsp_valid, cmd_ready}, rsp_payload_outputs_0, e);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL hold_release: rsp/ready=%b required 01",
                     {rsp_valid, cmd_ready});
        end
        exp_rsp.push_back(32'd0);
        @(negedge clk);
        cmd_valid = 1'b0;
        e = exp_rsp.pop_front();
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_payload_outputs_0 !== e) begin
            n_err++;
            $display("FAIL hold_next_cmd: rsp_valid=%b data=%h required 1 %h",
                     rsp_valid, rsp_payload_outputs_0, e);
        end
        @(negedge clk);
    endtask

    task automatic test_exclusive;
        n_cmp++;
        if (overlap != 0 || exp_rsp.size() != 0) begin
            n_err++;
            $display("FAIL exclusive: overlap=%0d pending=%0d required 0 0",
                     overlap, exp_rsp.size());
        end
    endtask

    initial begin
        reset = 1'b1;
        #2;
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        test_reset();
        reset = 1'b1;
        @(negedge clk);
        test_empty_start();
        test_pass_through();
        test_run();
        test_backpressure();
        test_config_rejects();
        test_reset_mid_run();
        test_response_hold();
        test_exclusive();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
